dcache_linefill: RTL and testbench
==================================

Name: dcache_linefill

Overview:
Line-fill engine for the data cache. On a miss it fetches one cache line from the memory bus, critical word first with wrap-around, and writes every returned word into the four byte-lane SPRAMs that form the dcache data array. Each lane is one 32-entry x 8-bit single-port RAM. The block sits between the dcache miss logic (upstream) and the data-array SPRAMs (downstream). It also flags the critical word so the core can restart early.

Parameters:
ADDRBITS, 5, SPRAM address width; the data array holds 2**ADDRBITS words.
LINEWORDBITS, 3, log2 of words per line; 8 words/line, so 4 line slots.
SLOTBITS, ADDRBITS-LINEWORDBITS, width of the line-slot index.

Ports:
clk  input  1  system clock; all state changes on rising edge.
reset_n  input  1  asynchronous, active-low reset.
fill_req  input  1  start a fill; sampled only in IDLE.
fill_addr  input  32  byte address of the missing access; bits[1:0] ignored.
fill_slot  input  SLOTBITS  data-array line slot to fill.
fill_abort  input  1  abandon the current fill.
fill_busy  output  1  high from the accepted request until return to IDLE.
crit_valid  output  1  one-cycle pulse when the critical word is written.
crit_data  output  32  critical word; held until the next fill is accepted.
fill_done  output  1  one-cycle pulse after the last word is written.
mem_rdreq  output  1  word read request.
mem_addr  output  32  word-aligned read address.
mem_ack  input  1  memory accepted the request.
mem_rvalid  input  1  read data valid.
mem_rdata  input  32  read data.
ram_addr  output  ADDRBITS  SPRAM address, shared by all 4 lanes: {slot, word}.
ram_wdata  output  32  lane n receives bits [8n+7:8n].
ram_we  output  4  per-lane write enables.

Behaviour:
- Reset (async, reset_n=0): state IDLE.
  - All outputs 0: fill_busy, crit_valid, fill_done, mem_rdreq, ram_we, mem_addr, ram_addr, ram_wdata, crit_data.
- States: IDLE, REQ, WAIT, WRITE, DONE.
- IDLE: when fill_req=1, latch the following and go to REQ:
  - base = fill_addr[31:LINEWORDBITS+2];
  - start word = w0 = fill_addr[LINEWORDBITS+1:2];
  - slot = fill_slot;
  - count = 0;
  - fill_busy is set on the same edge.
- REQ: mem_rdreq=1 and mem_addr={base, w, 2'b00}, where w=(w0+count) mod 2**LINEWORDBITS.
  - Stay in REQ until mem_ack=1, then go to WAIT.
  - mem_rvalid while in REQ is ignored.
- WAIT: on mem_rvalid=1, capture mem_rdata and go to WRITE. Only one request is ever outstanding.
- WRITE: exactly one cycle.
  - ram_addr={slot, w}, ram_wdata=captured word, ram_we=4'hF.
  - If count==0: crit_valid=1 this cycle, and crit_data is loaded.
  - If count==2**LINEWORDBITS-1: go to DONE.
  - Otherwise increment count and go to REQ.
- DONE: fill_done=1 for one cycle, fill_busy drops, go to IDLE.
- ram_we is 0 in every state except WRITE. ram_addr and ram_wdata hold their last value outside WRITE.
- Word order: w wraps modulo the line length, e.g. w0=5 gives 5,6,7,0,1,2,3,4. The base address never increments.
- Latency: with mem_ack and mem_rvalid each arriving one cycle after they are awaited, a word takes 3 cycles (REQ, WAIT, WRITE). An 8-word fill takes 24 cycles plus DONE.
- fill_abort=1 in any state other than IDLE: go to IDLE on the next edge.
  - mem_rdreq, ram_we and fill_busy clear; no fill_done.
  - Words already written remain in the RAM; the miss logic invalidates the tag.
  - An abort in WRITE takes priority: no RAM write that cycle.
  - A response still outstanding after an abort is the bus's responsibility; the block ignores mem_rvalid in IDLE.
- fill_req while not IDLE is ignored. fill_req in the same cycle as a DONE pulse is not accepted; it is accepted in the following IDLE cycle.
- Reset mid-fill: immediate return to the reset state; no partial pulses.

Test Plan:
- Aligned fill: fill_addr=0x0000_1000, slot=2, memory returns word index*0x11111111, mem_ack and mem_rvalid one cycle late → mem_addr steps 0x1000..0x101C; ram_addr 16..23 each with ram_we=F; crit_data=0; fill_done at cycle 25.
- Critical-first wrap: fill_addr=0x0000_2014, slot=1 → mem_addr order 0x2014, 0x2018, 0x201C, 0x2000 … 0x2010; ram_addr 13,14,15,8..12; crit_valid on the first write only.
- Bus stalls: mem_ack delayed 5 cycles, then mem_rvalid delayed 7 cycles → mem_rdreq held stable with unchanged mem_addr; no ram_we until rvalid; spurious mem_rvalid during REQ is ignored.
- Abort: assert fill_abort in WRITE of word 3 → no ram_we that cycle, IDLE next cycle, fill_busy=0, no fill_done; a new fill_req afterwards completes normally.
- Req while busy, then reset: pulse fill_req during a fill → ignored, with no change to latched base or slot. Drop reset_n mid-WAIT → all outputs 0 immediately; after release, state is IDLE.

Source files
------------

// File: rtl/dcache_linefill.sv
// dcache_linefill: fetches one cache line from the memory bus, critical word
// first with wrap-around, and writes each returned word into the four
// byte-lane SPRAMs of the dcache data array. Only one bus read is ever
// outstanding; the critical word is flagged so the core can restart early.
module dcache_linefill #(
  parameter int ADDRBITS     = 5,
  parameter int LINEWORDBITS = 3,
  parameter int SLOTBITS     = ADDRBITS - LINEWORDBITS
) (
  input  logic                clk,
  input  logic                reset_n,
  // upstream miss logic
  input  logic                fill_req,
  input  logic [31:0]         fill_addr,
  input  logic [SLOTBITS-1:0] fill_slot,
  input  logic                fill_abort,
  output logic                fill_busy,
  output logic                crit_valid,
  output logic [31:0]         crit_data,
  output logic                fill_done,
  // memory bus
  output logic                mem_rdreq,
  output logic [31:0]         mem_addr,
  input  logic                mem_ack,
  input  logic                mem_rvalid,
  input  logic [31:0]         mem_rdata,
  // data-array SPRAMs (4 byte lanes sharing one address)
  output logic [ADDRBITS-1:0] ram_addr,
  output logic [31:0]         ram_wdata,
  output logic [3:0]          ram_we
);

  localparam int BASEBITS = 32 - LINEWORDBITS - 2;
  localparam logic [LINEWORDBITS-1:0] LAST_COUNT = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                  state_q,      state_d;
  logic [BASEBITS-1:0]     base_q,       base_d;
  logic [LINEWORDBITS-1:0] w0_q,         w0_d;
  logic [SLOTBITS-1:0]     slot_q,       slot_d;
  logic [LINEWORDBITS-1:0] count_q,      count_d;
  logic                    fill_busy_q,  fill_busy_d;
  logic                    crit_valid_q, crit_valid_d;
  logic [31:0]             crit_data_q,  crit_data_d;
  logic                    fill_done_q,  fill_done_d;
  logic                    mem_rdreq_q,  mem_rdreq_d;
  logic [31:0]             mem_addr_q,   mem_addr_d;
  logic [ADDRBITS-1:0]     ram_addr_q,   ram_addr_d;
  logic [31:0]             ram_wdata_q,  ram_wdata_d;

  // word index of the word currently in flight, and of the next request
  logic [LINEWORDBITS-1:0] word_cur;
  logic [LINEWORDBITS-1:0] word_next;

  // byte offset bits of the miss address carry no information for a fill
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = &{1'b0, fill_addr[1:0]};

  assign word_cur  = w0_q + count_q;
  assign word_next = w0_d + count_d;

  // Next-state and next-output computation; outputs are derived from the
  // state being entered so they are registered and line up with the state.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    w0_d         = w0_q;
    slot_d       = slot_q;
    count_d      = count_q;
    crit_data_d  = crit_data_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    crit_valid_d = 1'b0;

    if (state_q != S_IDLE && fill_abort) begin
      // abandon the fill; nothing captured this cycle is kept
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fill_req) begin
            base_d  = fill_addr[31:LINEWORDBITS+2];
            w0_d    = fill_addr[LINEWORDBITS+1:2];
            slot_d  = fill_slot;
            count_d = '0;
            state_d = S_REQ;
          end
        end
        S_REQ: begin
          if (mem_ack) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            // the write register doubles as the capture register
            ram_wdata_d = mem_rdata;
            ram_addr_d  = {slot_q, word_cur};
            if (count_q == '0) begin
              crit_data_d  = mem_rdata;
              crit_valid_d = 1'b1;
            end
            state_d = S_WRITE;
          end
        end
        S_WRITE: begin
          if (count_q == LAST_COUNT) begin
            state_d = S_DONE;
          end else begin
            count_d = count_q + 1'b1;
            state_d = S_REQ;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    fill_busy_d = (state_d != S_IDLE);
    mem_rdreq_d = (state_d == S_REQ);
    fill_done_d = (state_d == S_DONE);
    // the request address only moves when a new request is presented,
    // so it is stable for the whole time mem_rdreq is held
    if (state_d == S_REQ && state_q != S_REQ) begin
      mem_addr_d = {base_d, word_next, 2'b00};
    end else begin
      mem_addr_d = mem_addr_q;
    end
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      w0_q         <= '0;
      slot_q       <= '0;
      count_q      <= '0;
      fill_busy_q  <= 1'b0;
      crit_valid_q <= 1'b0;
      crit_data_q  <= '0;
      fill_done_q  <= 1'b0;
      mem_rdreq_q  <= 1'b0;
      mem_addr_q   <= '0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      w0_q         <= w0_d;
      slot_q       <= slot_d;
      count_q      <= count_d;
      fill_busy_q  <= fill_busy_d;
      crit_valid_q <= crit_valid_d;
      crit_data_q  <= crit_data_d;
      fill_done_q  <= fill_done_d;
      mem_rdreq_q  <= mem_rdreq_d;
      mem_addr_q   <= mem_addr_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
    end
  end

  assign fill_busy = fill_busy_q;
  assign crit_data = crit_data_q;
  assign fill_done = fill_done_q;
  assign mem_rdreq = mem_rdreq_q;
  assign mem_addr  = mem_addr_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

  // An abort arriving during WRITE must suppress that very write, so the
  // write strobe and critical-word flag are gated by the live abort input.
  assign ram_we     = (state_q == S_WRITE && !fill_abort) ? 4'hF : 4'h0;
  assign crit_valid = crit_valid_q & ~fill_abort;

endmodule

// File: tb/tb_dcache_linefill.sv
// Scoreboard bench for dcache_linefill: stimulus pushes expected bus
// requests, RAM writes, critical words and done pulses into queues; a
// monitor pops and compares whenever the DUT presents one of them.
module tb_dcache_linefill;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fill_req;
  logic [31:0] fill_addr;
  logic [1:0]  fill_slot;
  logic        fill_abort;
  logic        fill_busy;
  logic        crit_valid;
  logic [31:0] crit_data;
  logic        fill_done;
  logic        mem_rdreq;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [4:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_we;

  dcache_linefill dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .fill_req   (fill_req),
    .fill_addr  (fill_addr),
    .fill_slot  (fill_slot),
    .fill_abort (fill_abort),
    .fill_busy  (fill_busy),
    .crit_valid (crit_valid),
    .crit_data  (crit_data),
    .fill_done  (fill_done),
    .mem_rdreq  (mem_rdreq),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int wr_seen = 0;

  // scoreboard queues
  logic [31:0] q_maddr[$];
  logic [4:0]  q_raddr[$];
  logic [31:0] q_rdata[$];
  logic [31:0] q_crit[$];
  int          q_done[$];

  // bus model controls
  int          ack_delay = 0;
  int          rv_delay  = 0;
  bit          spurious  = 1'b0;
  logic [31:0] data_tag  = '0;

  // hand-derived tables for the wrap-around fill at 0x2014, slot 1
  logic [31:0] t2_maddr[8] = '{32'h2014, 32'h2018, 32'h201C, 32'h2000,
                               32'h2004, 32'h2008, 32'h200C, 32'h2010};
  logic [4:0]  t2_raddr[8] = '{5'd13, 5'd14, 5'd15, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12};
  int          t2_word[8]  = '{5, 6, 7, 0, 1, 2, 3, 4};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: unexpected event, value %h (cycle %0d)", name, act, cyc);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_fill_busy"},  32'(fill_busy),  32'h0);
    chk({tag, "_crit_valid"}, 32'(crit_valid), 32'h0);
    chk({tag, "_fill_done"},  32'(fill_done),  32'h0);
    chk({tag, "_mem_rdreq"},  32'(mem_rdreq),  32'h0);
    chk({tag, "_ram_we"},     32'(ram_we),     32'h0);
    chk({tag, "_mem_addr"},   mem_addr,        32'h0);
    chk({tag, "_ram_addr"},   32'(ram_addr),   32'h0);
    chk({tag, "_ram_wdata"},  ram_wdata,       32'h0);
    chk({tag, "_crit_data"},  crit_data,       32'h0);
  endtask

  function automatic logic [31:0] word_data(input logic [2:0] w, input logic [31:0] tag);
    return (32'(w) * 32'h1111_1111) ^ tag;
  endfunction

  // generic reference: critical word first, wrap inside the line
  // done_exp: >=0 timed done pulse, -1 untimed done pulse, -2 no done pulse
  task automatic push_model(input logic [31:0] addr, input logic [1:0] slot,
                            input int nreq, input int nwr, input int done_exp);
    logic [2:0] w0;
    logic [2:0] w;
    w0 = addr[4:2];
    for (int i = 0; i < nreq; i++) begin
      w = w0 + 3'(i);
      q_maddr.push_back({addr[31:5], w, 2'b00});
      if (i < nwr) begin
        q_raddr.push_back({slot, w});
        q_rdata.push_back(word_data(w, data_tag));
      end
    end
    if (nwr > 0) q_crit.push_back(word_data(w0, data_tag));
    if (done_exp >= -1) q_done.push_back(done_exp);
  endtask

  // drive a fill request at posedge+1; returns at the next posedge+1
  task automatic start_fill(input logic [31:0] addr, input logic [1:0] slot);
    fill_req  = 1'b1;
    fill_addr = addr;
    fill_slot = slot;
    @(posedge clk); #1;
    fill_req  = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (fill_busy && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", 32'(fill_busy), 32'h0);
  endtask

  // cycle counter
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // memory bus model: drives mid-cycle so the DUT samples it on the next edge
  initial begin
    int          phase;
    int          ack_cnt;
    int          rv_cnt;
    logic [31:0] lat;
    phase = 0; ack_cnt = 0; rv_cnt = 0; lat = '0;
    mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #2;
      mem_ack    = 1'b0;
      mem_rvalid = 1'b0;
      if (!reset_n) begin
        phase = 0; ack_cnt = 0; rv_cnt = 0;
      end else if (phase == 0) begin
        if (mem_rdreq) begin
          if (spurious && ack_cnt == 1) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hDEAD_BEEF;
          end
          if (ack_cnt >= ack_delay) begin
            mem_ack = 1'b1;
            lat     = mem_addr;
            phase   = 1;
            ack_cnt = 0;
            rv_cnt  = 0;
          end else begin
            ack_cnt++;
          end
        end
      end else begin
        if (rv_cnt >= rv_delay) begin
          mem_rvalid = 1'b1;
          mem_rdata  = word_data(lat[4:2], data_tag);
          phase      = 0;
        end else begin
          rv_cnt++;
        end
      end
    end
  end

  // monitor: compares every DUT-presented event against the scoreboard
  initial begin
    logic        prev_rdreq;
    logic [31:0] prev_maddr;
    int          e;
    prev_rdreq = 1'b0;
    prev_maddr = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_rdreq = 1'b0;
      end else begin
        if (mem_rdreq && prev_rdreq) chk("mem_addr_stable", mem_addr, prev_maddr);
        if (mem_rdreq && mem_ack) begin
          if (q_maddr.size() == 0) unexpected("mem_req", mem_addr);
          else chk("mem_addr", mem_addr, q_maddr.pop_front());
        end
        if (ram_we != 4'h0) begin
          wr_seen++;
          chk("ram_we", 32'(ram_we), 32'hF);
          if (q_raddr.size() == 0) unexpected("ram_write", 32'(ram_addr));
          else begin
            chk("ram_addr", 32'(ram_addr), 32'(q_raddr.pop_front()));
            chk("ram_wdata", ram_wdata, q_rdata.pop_front());
          end
          $display("write: cycle %0d ram_addr=%0d ram_wdata=%h crit=%0b", cyc, ram_addr, ram_wdata, crit_valid);
        end
        if (crit_valid) begin
          if (q_crit.size() == 0) unexpected("crit_valid", crit_data);
          else chk("crit_data", crit_data, q_crit.pop_front());
        end
        if (fill_done) begin
          if (q_done.size() == 0) unexpected("fill_done", 32'(cyc));
          else begin
            e = q_done.pop_front();
            if (e >= 0) chk("done_cycle", 32'(cyc), 32'(e));
          end
          $display("done: cycle %0d", cyc);
        end
        prev_rdreq = mem_rdreq;
        prev_maddr = mem_addr;
      end
    end
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // directed stimulus
  initial begin
    int n;
    int wr0;
    reset_n    = 1'b0;
    fill_req   = 1'b0;
    fill_addr  = '0;
    fill_slot  = '0;
    fill_abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;

    // aligned fill, slot 2, data = word index * 0x11111111
    data_tag = 32'h0;
    n = cyc;
    for (int i = 0; i < 8; i++) begin
      q_maddr.push_back(32'h1000 + 32'(i) * 4);
      q_raddr.push_back(5'(16 + i));
      q_rdata.push_back(32'(i) * 32'h1111_1111);
    end
    q_crit.push_back(32'h0);
    q_done.push_back(n + 25);
    start_fill(32'h0000_1000, 2'd2);
    chk("busy_after_accept", 32'(fill_busy), 32'h1);
    wait_idle(100);

    // critical-word-first wrap, slot 1
    @(posedge clk); #1;
    data_tag = 32'h00A0_0000;
    n = cyc;
    for (int i = 0; i < 8; i++) begin
      q_maddr.push_back(t2_maddr[i]);
      q_raddr.push_back(t2_raddr[i]);
      q_rdata.push_back(word_data(3'(t2_word[i]), data_tag));
    end
    q_crit.push_back(word_data(3'd5, data_tag));
    q_done.push_back(n + 25);
    start_fill(32'h0000_2014, 2'd1);
    wait_idle(100);

    // bus stalls with a spurious rvalid while waiting for ack
    @(posedge clk); #1;
    ack_delay = 5; rv_delay = 7; spurious = 1'b1;
    data_tag  = 32'h0B00_0000;
    push_model(32'h0000_3008, 2'd3, 8, 8, -1);
    start_fill(32'h0000_3008, 2'd3);
    wait_idle(400);
    ack_delay = 0; rv_delay = 0; spurious = 1'b0;

    // abort during WRITE of the fourth word
    @(posedge clk); #1;
    data_tag = 32'h00C0_0000;
    push_model(32'h0000_400C, 2'd0, 4, 3, -2);
    wr0 = wr_seen;
    start_fill(32'h0000_400C, 2'd0);
    for (int i = 0; i < 100 && wr_seen < wr0 + 3; i++) @(posedge clk);
    chk("abort_wait_writes", 32'(wr_seen - wr0), 32'd3);
    @(posedge clk);
    @(posedge clk); #1;
    fill_abort = 1'b1;
    @(negedge clk);
    chk("abort_no_we", 32'(ram_we), 32'h0);
    @(posedge clk); #1;
    fill_abort = 1'b0;
    chk("abort_busy", 32'(fill_busy), 32'h0);
    chk("abort_rdreq", 32'(mem_rdreq), 32'h0);
    chk("abort_done", 32'(fill_done), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    data_tag = 32'h00D0_0000;
    n = cyc;
    push_model(32'h0000_5000, 2'd1, 8, 8, n + 25);
    start_fill(32'h0000_5000, 2'd1);
    wait_idle(100);

    // request while busy is ignored; request during DONE waits for IDLE
    @(posedge clk); #1;
    data_tag = 32'h00E0_0000;
    n = cyc;
    push_model(32'h0000_6018, 2'd2, 8, 8, n + 25);
    push_model(32'h0000_7004, 2'd0, 8, 8, n + 51);
    start_fill(32'h0000_6018, 2'd2);
    repeat (3) @(posedge clk);
    #1;
    start_fill(32'h7777_0000, 2'd0);
    while (cyc < n + 25) @(posedge clk);
    #1;
    chk("done_pulse_cycle", 32'(fill_done), 32'h1);
    fill_req  = 1'b1;
    fill_addr = 32'h0000_7004;
    fill_slot = 2'd0;
    @(posedge clk); #1;
    chk("busy_low_in_idle", 32'(fill_busy), 32'h0);
    @(posedge clk); #1;
    fill_req = 1'b0;
    chk("req_accepted_after_done", 32'(fill_busy), 32'h1);
    wait_idle(100);

    // reset in the middle of WAIT
    @(posedge clk); #1;
    data_tag = 32'h00F0_0000;
    push_model(32'h0000_8000, 2'd3, 1, 0, -2);
    start_fill(32'h0000_8000, 2'd3);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_busy", 32'(fill_busy), 32'h0);
    chk("post_reset_rdreq", 32'(mem_rdreq), 32'h0);
    data_tag = 32'h0110_0000;
    n = cyc;
    push_model(32'h0000_9004, 2'd0, 8, 8, n + 25);
    start_fill(32'h0000_9004, 2'd0);
    wait_idle(100);

    repeat (3) @(posedge clk);
    #1;
    chk("left_mem_reqs",  32'(q_maddr.size()), 32'h0);
    chk("left_ram_writes", 32'(q_raddr.size()), 32'h0);
    chk("left_crit",      32'(q_crit.size()),  32'h0);
    chk("left_done",      32'(q_done.size()),  32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
